// File: rtl/rx_udp.sv
// UDP receive stage: parses the 8-byte UDP header from the IPv4 payload stream, filters on
// destination port and forwards only the datagram payload with SOP/EOP, trimming padding.
module rx_udp #(
    parameter int OCT     = 8,
    parameter int UDP_HDR = 8
) (
    input  logic               RX_CLK,
    input  logic               rst_n,
    input  logic [2*OCT-1:0]   udp_port,
    input  logic [4*OCT-1:0]   rx_src_ip,
    input  logic               rx_data_udp,
    input  logic [OCT-1:0]     rx_data,
    output logic               rx_udp_valid,
    output logic [OCT-1:0]     rx_udp_data,
    output logic               rx_udp_sop,
    output logic               rx_udp_eop,
    output logic [2*OCT-1:0]   rx_udp_src_port,
    output logic [4*OCT-1:0]   rx_udp_src_ip,
    output logic [2*OCT-1:0]   rx_udp_len,
    output logic               rx_udp_err
);

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    localparam logic [2:0]       HDR_LAST = 3'(UDP_HDR - 1);
    localparam logic [2*OCT-1:0] HDR_LEN  = (2*OCT)'(UDP_HDR);

    state_t             state_r, state_s;
    logic [2:0]         cnt_r, cnt_s;
    logic [2*OCT-1:0]   src_port_r, src_port_s;
    logic [2*OCT-1:0]   dst_port_r, dst_port_s;
    logic [2*OCT-1:0]   len_r, len_s;
    logic [2*OCT-1:0]   remaining_r, remaining_s;
    logic               first_r, first_s;

    logic               valid_s, sop_s, eop_s, err_s;
    logic [OCT-1:0]     data_s;
    logic [2*OCT-1:0]   out_port_s, out_len_s;
    logic [4*OCT-1:0]   out_ip_s;

    // Next-state, header field capture and payload output decode
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        src_port_s  = src_port_r;
        dst_port_s  = dst_port_r;
        len_s       = len_r;
        remaining_s = remaining_r;
        first_s     = first_r;
        valid_s     = 1'b0;
        sop_s       = 1'b0;
        eop_s       = 1'b0;
        err_s       = 1'b0;
        data_s      = rx_udp_data;
        out_port_s  = rx_udp_src_port;
        out_ip_s    = rx_udp_src_ip;
        out_len_s   = rx_udp_len;

        if (!rx_data_udp) begin
            // A frame boundary while payload is still owed means the datagram was cut short
            if (state_r == ST_PAYLOAD) begin
                err_s = 1'b1;
            end else begin
                err_s = 1'b0;
            end
            state_s = ST_HDR;
            cnt_s   = 3'd0;
        end else begin
            case (state_r)
                ST_HDR: begin
                    // Checksum bytes (6-7) are not verified, so they are simply counted past
                    case (cnt_r)
                        3'd0, 3'd1: src_port_s = {src_port_r[OCT-1:0], rx_data};
                        3'd2, 3'd3: dst_port_s = {dst_port_r[OCT-1:0], rx_data};
                        3'd4, 3'd5: len_s      = {len_r[OCT-1:0], rx_data};
                        default:    len_s      = len_r;
                    endcase
                    if (cnt_r == HDR_LAST) begin
                        cnt_s = 3'd0;
                        if ((dst_port_r == udp_port) && (len_r > HDR_LEN)) begin
                            state_s     = ST_PAYLOAD;
                            remaining_s = len_r - HDR_LEN;
                            first_s     = 1'b1;
                            out_port_s  = src_port_r;
                            out_ip_s    = rx_src_ip;
                            out_len_s   = len_r - HDR_LEN;
                        end else begin
                            state_s = ST_DROP;
                        end
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end
                ST_PAYLOAD: begin
                    valid_s     = 1'b1;
                    data_s      = rx_data;
                    sop_s       = first_r;
                    first_s     = 1'b0;
                    remaining_s = remaining_r - (2*OCT)'(1);
                    if (remaining_r == (2*OCT)'(1)) begin
                        eop_s   = 1'b1;
                        state_s = ST_DROP;
                    end else begin
                        eop_s   = 1'b0;
                    end
                end
                ST_DROP: begin
                    state_s = ST_DROP;
                end
                default: begin
                    state_s = ST_HDR;
                    cnt_s   = 3'd0;
                end
            endcase
        end
    end

    // Parser state registers
    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_HDR;
            cnt_r       <= 3'd0;
            src_port_r  <= '0;
            dst_port_r  <= '0;
            len_r       <= '0;
            remaining_r <= '0;
            first_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            src_port_r  <= src_port_s;
            dst_port_r  <= dst_port_s;
            len_r       <= len_s;
            remaining_r <= remaining_s;
            first_r     <= first_s;
        end
    end

    // Registered outputs, one cycle behind the accepted input byte
    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_udp_valid    <= 1'b0;
            rx_udp_data     <= '0;
            rx_udp_sop      <= 1'b0;
            rx_udp_eop      <= 1'b0;
            rx_udp_err      <= 1'b0;
            rx_udp_src_port <= '0;
            rx_udp_src_ip   <= '0;
            rx_udp_len      <= '0;
        end else begin
            rx_udp_valid    <= valid_s;
            rx_udp_data     <= data_s;
            rx_udp_sop      <= sop_s;
            rx_udp_eop      <= eop_s;
            rx_udp_err      <= err_s;
            rx_udp_src_port <= out_port_s;
            rx_udp_src_ip   <= out_ip_s;
            rx_udp_len      <= out_len_s;
        end
    end

endmodule

// File: tb/tb_rx_udp.sv
// Directed bench for rx_udp: expected payload bytes and error pulses are queued as stimulus is
// driven and checked, including their arrival cycle, as the DUT presents them.
module tb_rx_udp;

    logic        RX_CLK;
    logic        rst_n;
    logic [15:0] udp_port;
    logic [31:0] rx_src_ip;
    logic        rx_data_udp;
    logic [7:0]  rx_data;
    logic        rx_udp_valid;
    logic [7:0]  rx_udp_data;
    logic        rx_udp_sop;
    logic        rx_udp_eop;
    logic [15:0] rx_udp_src_port;
    logic [31:0] rx_udp_src_ip;
    logic [15:0] rx_udp_len;
    logic        rx_udp_err;

    typedef struct packed {
        logic [7:0]  d;
        logic        sop;
        logic        eop;
        logic [31:0] cyc;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] err_q[$];
    logic [31:0] cyc;
    int          tests;
    int          fails;

    rx_udp dut (
        .RX_CLK          (RX_CLK),
        .rst_n           (rst_n),
        .udp_port        (udp_port),
        .rx_src_ip       (rx_src_ip),
        .rx_data_udp     (rx_data_udp),
        .rx_data         (rx_data),
        .rx_udp_valid    (rx_udp_valid),
        .rx_udp_data     (rx_udp_data),
        .rx_udp_sop      (rx_udp_sop),
        .rx_udp_eop      (rx_udp_eop),
        .rx_udp_src_port (rx_udp_src_port),
        .rx_udp_src_ip   (rx_udp_src_ip),
        .rx_udp_len      (rx_udp_len),
        .rx_udp_err      (rx_udp_err)
    );

    initial begin
        RX_CLK = 1'b0;
        forever #5 RX_CLK = ~RX_CLK;
    end

    initial cyc = 32'd0;
    always @(posedge RX_CLK) cyc <= cyc + 32'd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every valid byte and error pulse must match the head of its queue
    always @(negedge RX_CLK) begin
        if (rst_n) begin
            if (rx_udp_valid === 1'b1) begin
                chk("valid_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("data", 64'(rx_udp_data), 64'(e.d));
                    chk("sop", 64'(rx_udp_sop), 64'(e.sop));
                    chk("eop", 64'(rx_udp_eop), 64'(e.eop));
                    chk("latency", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                if ((rx_udp_sop !== 1'b0) || (rx_udp_eop !== 1'b0))
                    chk("sop_eop_idle", {62'd0, rx_udp_sop, rx_udp_eop}, 64'd0);
            end
            if (rx_udp_err !== 1'b0) begin
                chk("err_expected", 64'(err_q.size() != 0), 64'd1);
                if (err_q.size() != 0) chk("err_cycle", 64'(cyc), 64'(err_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic [7:0] b);
        @(negedge RX_CLK);
        rx_data_udp = 1'b1;
        rx_data     = b;
    endtask

    task automatic pay(input logic [7:0] b, input logic sop, input logic eop);
        sb_t e;
        drive(b);
        e.d = b; e.sop = sop; e.eop = eop; e.cyc = cyc + 32'd1;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge RX_CLK);
            rx_data_udp = 1'b0;
            rx_data     = 8'h00;
        end
    endtask

    task automatic hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        drive(src[15:8]); drive(src[7:0]);
        drive(dst[15:8]); drive(dst[7:0]);
        drive(len[15:8]); drive(len[7:0]);
        drive(8'h00);     drive(8'h00);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        chk({tag, "_err_empty"}, 64'(err_q.size()), 64'd0);
        sb_q.delete();
        err_q.delete();
    endtask

    task automatic fields(input string tag, input logic [15:0] port, input logic [15:0] len,
                          input logic [31:0] ip);
        chk({tag, "_src_port"}, 64'(rx_udp_src_port), 64'(port));
        chk({tag, "_len"}, 64'(rx_udp_len), 64'(len));
        chk({tag, "_src_ip"}, 64'(rx_udp_src_ip), 64'(ip));
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_flags"}, {60'd0, rx_udp_valid, rx_udp_sop, rx_udp_eop, rx_udp_err}, 64'd0);
        chk({tag, "_data"}, 64'(rx_udp_data), 64'd0);
        fields(tag, 16'h0000, 16'h0000, 32'h0000_0000);
    endtask

    task automatic dgram1(input logic [31:0] ip);
        rx_src_ip = ip;
        hdr(16'h1F90, 16'h04D2, 16'h000C);
        pay(8'hDE, 1'b1, 1'b0);
        pay(8'hAD, 1'b0, 1'b0);
        pay(8'hBE, 1'b0, 1'b0);
        pay(8'hEF, 1'b0, 1'b1);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        rx_data_udp = 1'b0;
        rx_data     = 8'h00;
        udp_port    = 16'h04D2;
        rx_src_ip   = 32'h0A00_0001;
        idle(2);
        all_zero("reset");
        rst_n = 1'b1;
        idle(2);
        all_zero("post_reset");

        // Basic datagram
        dgram1(32'hC0A8_0001);
        idle(3);
        drained("t1");
        fields("t1", 16'h1F90, 16'h0004, 32'hC0A8_0001);

        // Padding after payload, then a second frame
        dgram1(32'hC0A8_0002);
        for (int i = 0; i < 14; i++) drive(8'hA5);
        idle(2);
        rx_src_ip = 32'hC0A8_0003;
        hdr(16'h2222, 16'h04D2, 16'h000A);
        pay(8'h55, 1'b1, 1'b0);
        pay(8'h66, 1'b0, 1'b1);
        idle(3);
        drained("t2");
        fields("t2", 16'h2222, 16'h0002, 32'hC0A8_0003);

        // Port mismatch: nothing out, held fields untouched
        rx_src_ip = 32'hC0A8_0004;
        hdr(16'h1111, 16'h0035, 16'h000C);
        for (int i = 0; i < 4; i++) drive(8'h10 + 8'(i));
        idle(3);
        drained("t3");
        fields("t3", 16'h2222, 16'h0002, 32'hC0A8_0003);

        // Short header is dropped silently
        for (int i = 0; i < 5; i++) drive(8'h04);
        idle(3);
        drained("short_hdr");

        // Truncated datagram
        rx_src_ip = 32'hC0A8_0005;
        hdr(16'h3333, 16'h04D2, 16'h000C);
        pay(8'hA1, 1'b1, 1'b0);
        pay(8'hA2, 1'b0, 1'b0);
        @(negedge RX_CLK);
        rx_data_udp = 1'b0;
        err_q.push_back(cyc + 32'd1);
        idle(3);
        drained("t4");
        fields("t4", 16'h3333, 16'h0004, 32'hC0A8_0005);

        // Single-byte payload, then lengths 8 and 4
        rx_src_ip = 32'hC0A8_0006;
        hdr(16'h4444, 16'h04D2, 16'h0009);
        pay(8'h7E, 1'b1, 1'b1);
        drive(8'h00); drive(8'h00);
        idle(3);
        rx_src_ip = 32'hC0A8_0016;
        hdr(16'h5555, 16'h04D2, 16'h0008);
        idle(3);
        hdr(16'h6666, 16'h04D2, 16'h0004);
        drive(8'h01); drive(8'h02);
        idle(3);
        drained("t5");
        fields("t5", 16'h4444, 16'h0001, 32'hC0A8_0006);

        // Asynchronous reset in the middle of a payload
        rx_src_ip = 32'hC0A8_0007;
        hdr(16'h7777, 16'h04D2, 16'h000C);
        pay(8'h11, 1'b1, 1'b0);
        pay(8'h22, 1'b0, 1'b0);
        @(negedge RX_CLK);
        rx_data = 8'h33;
        #2;
        chk("pre_rst_valid", 64'(rx_udp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        all_zero("async_rst");
        @(negedge RX_CLK);
        rx_data_udp = 1'b0;
        @(negedge RX_CLK);
        rst_n = 1'b1;
        idle(2);
        drained("t6_rst");
        dgram1(32'hC0A8_0008);
        idle(3);
        drained("t6");
        fields("t6", 16'h1F90, 16'h0004, 32'hC0A8_0008);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
